// File: rtl/button_conditioner.sv
// Button conditioner: synchronizes raw, bouncy button pins and turns each one
// into a debounced level plus press/release/long-press pulses and a toggle.
// Every button has its own copy of the same FSM, all running on CLK.
module button_conditioner #(
  parameter int NBTN            = 3,
  parameter int ACTIVE_LOW      = 1,
  parameter int DEBOUNCE_CYCLES = 240000,
  parameter int LONG_CYCLES     = 12000000
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [NBTN-1:0] BTN,
  output logic [NBTN-1:0] BTN_STATE,
  output logic [NBTN-1:0] BTN_PRESS,
  output logic [NBTN-1:0] BTN_RELEASE,
  output logic [NBTN-1:0] BTN_TOGGLE,
  output logic [NBTN-1:0] BTN_LONG
);

  localparam int CNT_W  = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int HOLD_W = $clog2(LONG_CYCLES) + 1;

  localparam logic [CNT_W-1:0]  DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_CYCLES);
  localparam logic [HOLD_W-1:0] LONG_HIT = HOLD_W'(LONG_CYCLES - 1);

  // Raw pin level that means "not pressed"; the synchronizer resets to it so
  // the corrected signal reads released straight out of reset.
  localparam logic [NBTN-1:0] IDLE_LEVEL = {NBTN{(ACTIVE_LOW != 0)}};

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_PEND   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_PEND = 2'd3
  } state_t;

  logic [NBTN-1:0] sync_p0;
  logic [NBTN-1:0] sync_p1;
  logic [NBTN-1:0] s;

  // Two-flop synchronizer for the asynchronous pins.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync_p0 <= IDLE_LEVEL;
      sync_p1 <= IDLE_LEVEL;
    end else begin
      sync_p0 <= BTN;
      sync_p1 <= sync_p0;
    end
  end

  // Polarity correction: s = 1 means pressed regardless of board wiring.
  assign s = (ACTIVE_LOW != 0) ? ~sync_p1 : sync_p1;

  for (genvar i = 0; i < NBTN; i++) begin : g_btn
    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [HOLD_W-1:0] hold, hold_nxt, hold_inc;
    logic              level, level_nxt;
    logic              press, press_nxt;
    logic              release_q, release_nxt;
    logic              toggle, toggle_nxt;
    logic              long_q, long_nxt;

    assign hold_inc = hold + 1'b1;

    // State, counters and registered outputs for this button.
    always_ff @(posedge CLK) begin
      if (RST) begin
        state     <= RELEASED;
        cnt       <= '0;
        hold      <= '0;
        level     <= 1'b0;
        press     <= 1'b0;
        release_q <= 1'b0;
        toggle    <= 1'b0;
        long_q    <= 1'b0;
      end else begin
        state     <= state_nxt;
        cnt       <= cnt_nxt;
        hold      <= hold_nxt;
        level     <= level_nxt;
        press     <= press_nxt;
        release_q <= release_nxt;
        toggle    <= toggle_nxt;
        long_q    <= long_nxt;
      end
    end

    // Debounce FSM: a change is accepted only after DEBOUNCE_CYCLES
    // consecutive samples at the new level; pulses are computed here and
    // registered above so they appear together with the level change.
    always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      hold_nxt    = hold;
      level_nxt   = level;
      press_nxt   = 1'b0;
      release_nxt = 1'b0;
      toggle_nxt  = toggle;
      long_nxt    = 1'b0;
      unique case (state)
        RELEASED: begin
          if (s[i]) begin
            state_nxt = PRESS_PEND;
            cnt_nxt   = CNT_W'(1);
          end else begin
            cnt_nxt = '0;
          end
        end
        PRESS_PEND: begin
          if (!s[i]) begin
            state_nxt = RELEASED;
            cnt_nxt   = '0;
          end else if (cnt == DEB_LAST) begin
            state_nxt  = PRESSED;
            cnt_nxt    = '0;
            level_nxt  = 1'b1;
            press_nxt  = 1'b1;
            toggle_nxt = ~toggle;
            hold_nxt   = '0;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
        PRESSED: begin
          cnt_nxt = '0;
          if (!s[i]) begin
            state_nxt = RELEASE_PEND;
            cnt_nxt   = CNT_W'(1);
          end else if (hold != HOLD_MAX) begin
            // Saturating at LONG_CYCLES guarantees a single long pulse per press.
            hold_nxt = hold_inc;
            long_nxt = (hold_inc == LONG_HIT);
          end
        end
        RELEASE_PEND: begin
          if (s[i]) begin
            // Release glitch: resume the press, hold time keeps accumulating.
            state_nxt = PRESSED;
            cnt_nxt   = '0;
          end else if (cnt == DEB_LAST) begin
            state_nxt   = RELEASED;
            cnt_nxt     = '0;
            level_nxt   = 1'b0;
            release_nxt = 1'b1;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
        default: begin
          state_nxt = RELEASED;
          cnt_nxt   = '0;
        end
      endcase
    end

    assign BTN_STATE[i]   = level;
    assign BTN_PRESS[i]   = press;
    assign BTN_RELEASE[i] = release_q;
    assign BTN_TOGGLE[i]  = toggle;
    assign BTN_LONG[i]    = long_q;
  end

endmodule
